mips_multiport_regfile: RTL and testbench

Parametrised multi-port register file for MIPS-based cores: configurable depth, data width, number of read and write ports, and read mode. Adds a post-reset zero-initialisation sweep with a `ready` flag, deterministic write-port priority with collision reporting, and an optional hard-wired zero register. Sits between decode (read addresses) and writeback (write ports); multi-issue variants use NWR > 1.

---
 rtl/mips_multiport_regfile.sv | 122 ++++++++++++
 tb/tb_mips_multiport_regfile.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multiport_regfile.sv
// Multi-port register file for MIPS cores: NRD read ports, NWR write ports,
// a post-reset zero sweep gated by 'ready', highest-index-wins write priority
// with a registered clash flag, optional hard-wired r0, and three read modes
// (0 = combinational, 1 = registered write-first, 2 = registered read-first).
module mips_multiport_regfile #(
    parameter int unsigned DWL      = 32,
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned NRD      = 2,
    parameter int unsigned NWR      = 1,
    parameter int unsigned MODE     = 0,
    parameter bit          ZERO_REG = 1'b1,
    localparam int unsigned AWL     = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NWR-1:0]       wen,
    input  logic [NWR*AWL-1:0]   WA,
    input  logic [NWR*DWL-1:0]   WD,
    input  logic [NRD*AWL-1:0]   RA,
    output logic [NRD*DWL-1:0]   RD,
    output logic                 ready,
    output logic                 wr_collision
);

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t             state;
    logic [AWL-1:0]     sweep_cnt;
    logic [DWL-1:0]     mem [DEPTH];
    logic [NWR-1:0]     wr_ok;
    logic               clash;
    logic [NRD*DWL-1:0] rd_now;
    logic [NRD*DWL-1:0] rd_fwd;
    logic [NRD*DWL-1:0] rd_p1;

    // An address is real storage only if it is inside the array and is not
    // the hard-wired zero register.
    function automatic logic addr_ok(input logic [AWL-1:0] a);
        return (32'(a) < DEPTH) && !((ZERO_REG == 1'b1) && (a == '0));
    endfunction

    // Qualify each write port: enabled, in RUN, and aimed at real storage.
    always_comb begin
        wr_ok = '0;
        for (int k = 0; k < NWR; k++)
            wr_ok[k] = wen[k] && (state == S_RUN) && addr_ok(WA[k*AWL +: AWL]);
    end

    // Clash detection only looks at qualified ports, so dropped writes never count.
    always_comb begin
        clash = 1'b0;
        for (int i = 0; i < NWR; i++)
            for (int j = i + 1; j < NWR; j++)
                if (wr_ok[i] && wr_ok[j] && (WA[i*AWL +: AWL] == WA[j*AWL +: AWL]))
                    clash = 1'b1;
    end

    // Init sweep FSM: walk every entry once after reset, then stay in RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_INIT;
            sweep_cnt    <= '0;
            ready        <= 1'b0;
            wr_collision <= 1'b0;
        end else begin
            wr_collision <= clash;
            case (state)
                S_INIT: begin
                    if (sweep_cnt == AWL'(DEPTH - 1)) begin
                        state <= S_RUN;
                        ready <= 1'b1;
                    end else begin
                        sweep_cnt <= sweep_cnt + 1'b1;
                    end
                end
                default: state <= S_RUN;
            endcase
        end
    end

    // Storage: zero fill during INIT, otherwise ascending port order so the
    // highest-index port lands last and wins an address clash.
    always_ff @(posedge clk) begin
        if (state == S_INIT) begin
            mem[sweep_cnt] <= '0;
        end else begin
            for (int k = 0; k < NWR; k++)
                if (wr_ok[k])
                    mem[WA[k*AWL +: AWL]] <= WD[k*DWL +: DWL];
        end
    end

    // Raw array read; zero while sweeping, for r0 and for out-of-range addresses.
    always_comb begin
        rd_now = '0;
        for (int j = 0; j < NRD; j++)
            if ((state == S_RUN) && addr_ok(RA[j*AWL +: AWL]))
                rd_now[j*DWL +: DWL] = mem[RA[j*AWL +: AWL]];
    end

    // Write-first view: bypass the winning same-cycle write onto the read port.
    always_comb begin
        rd_fwd = rd_now;
        for (int j = 0; j < NRD; j++)
            for (int k = 0; k < NWR; k++)
                if (wr_ok[k] && (WA[k*AWL +: AWL] == RA[j*AWL +: AWL]))
                    rd_fwd[j*DWL +: DWL] = WD[k*DWL +: DWL];
    end

    // Registered read data for modes 1 and 2, cleared immediately on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rd_p1 <= '0;
        else if (MODE == 1)
            rd_p1 <= rd_fwd;
        else
            rd_p1 <= rd_now;
    end

    assign RD = (MODE == 0) ? rd_now : rd_p1;

endmodule

// File: tb/tb_mips_multiport_regfile.sv
// Bench for mips_multiport_regfile: five configurations share one set of
// stimulus and are compared against an array-based reference model.
module tb_mips_multiport_regfile;

    localparam int NC = 5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  wen;
    logic [9:0]  wa;
    logic [63:0] wd;
    logic [9:0]  ra;
    logic [63:0] rd_o   [NC];
    logic        rdy_o  [NC];
    logic        coll_o [NC];

    always #5 clk = ~clk;

    // u0: async, r0 wired; u1: write-first; u2: read-first; u3: async, r0 plain;
    // u4: write-first with 20 entries (addresses 20..31 out of range).
    int cfg_mode  [NC] = '{0, 1, 2, 0, 1};
    int cfg_zr    [NC] = '{1, 1, 1, 0, 1};
    int cfg_depth [NC] = '{32, 32, 32, 32, 20};

    mips_multiport_regfile #(.DWL(32), .DEPTH(32), .NRD(2), .NWR(2), .MODE(0), .ZERO_REG(1'b1)) u0 (
        .clk(clk), .rst_n(rst_n), .wen(wen), .WA(wa), .WD(wd), .RA(ra),
        .RD(rd_o[0]), .ready(rdy_o[0]), .wr_collision(coll_o[0]));
    mips_multiport_regfile #(.DWL(32), .DEPTH(32), .NRD(2), .NWR(2), .MODE(1), .ZERO_REG(1'b1)) u1 (
        .clk(clk), .rst_n(rst_n), .wen(wen), .WA(wa), .WD(wd), .RA(ra),
        .RD(rd_o[1]), .ready(rdy_o[1]), .wr_collision(coll_o[1]));
    mips_multiport_regfile #(.DWL(32), .DEPTH(32), .NRD(2), .NWR(2), .MODE(2), .ZERO_REG(1'b1)) u2 (
        .clk(clk), .rst_n(rst_n), .wen(wen), .WA(wa), .WD(wd), .RA(ra),
        .RD(rd_o[2]), .ready(rdy_o[2]), .wr_collision(coll_o[2]));
    mips_multiport_regfile #(.DWL(32), .DEPTH(32), .NRD(2), .NWR(2), .MODE(0), .ZERO_REG(1'b0)) u3 (
        .clk(clk), .rst_n(rst_n), .wen(wen), .WA(wa), .WD(wd), .RA(ra),
        .RD(rd_o[3]), .ready(rdy_o[3]), .wr_collision(coll_o[3]));
    mips_multiport_regfile #(.DWL(32), .DEPTH(20), .NRD(2), .NWR(2), .MODE(1), .ZERO_REG(1'b1)) u4 (
        .clk(clk), .rst_n(rst_n), .wen(wen), .WA(wa), .WD(wd), .RA(ra),
        .RD(rd_o[4]), .ready(rdy_o[4]), .wr_collision(coll_o[4]));

    // Reference model state
    logic [31:0] mm    [NC][32];
    int          cnt_m [NC];
    bit          rdy_m [NC];
    logic [31:0] rdp_m [NC][2];
    bit          coll_m[NC];

    int n_cmp = 0;
    int n_bad = 0;

    function automatic int wa_of(int k);
        return int'(wa[k*5 +: 5]);
    endfunction

    function automatic int ra_of(int j);
        return int'(ra[j*5 +: 5]);
    endfunction

    function automatic bit eff(int c, int k);
        int a;
        a = wa_of(k);
        return wen[k] && (a < cfg_depth[c]) && !((cfg_zr[c] != 0) && (a == 0));
    endfunction

    function automatic logic [31:0] mread(int c, int a);
        if (!rdy_m[c] || a >= cfg_depth[c] || ((cfg_zr[c] != 0) && a == 0))
            return 32'd0;
        return mm[c][a];
    endfunction

    function automatic logic [31:0] exp_rd(int c, int j);
        if (cfg_mode[c] == 0)
            return mread(c, ra_of(j));
        return rdp_m[c][j];
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NC; c++) begin
            cnt_m[c]    = 0;
            rdy_m[c]    = 1'b0;
            rdp_m[c][0] = 32'd0;
            rdp_m[c][1] = 32'd0;
            coll_m[c]   = 1'b0;
        end
    endtask

    // One clock edge for the DUTs and the model; returns 1 time unit after the edge.
    task automatic tick();
        logic [31:0] nrd [NC][2];
        bit          ncoll [NC];
        logic [31:0] v;
        int          a;
        for (int c = 0; c < NC; c++) begin
            for (int j = 0; j < 2; j++) begin
                a = ra_of(j);
                v = mread(c, a);
                if (!rdy_m[c])
                    v = 32'd0;
                else if (cfg_mode[c] == 1)
                    for (int k = 0; k < 2; k++)
                        if (eff(c, k) && wa_of(k) == a)
                            v = wd[k*32 +: 32];
                nrd[c][j] = v;
            end
            ncoll[c] = rdy_m[c] && eff(c, 0) && eff(c, 1) && (wa_of(0) == wa_of(1));
        end
        @(posedge clk);
        for (int c = 0; c < NC; c++) begin
            if (rdy_m[c]) begin
                for (int k = 0; k < 2; k++)
                    if (eff(c, k))
                        mm[c][wa_of(k)] = wd[k*32 +: 32];
            end else begin
                cnt_m[c]++;
                if (cnt_m[c] >= cfg_depth[c]) begin
                    rdy_m[c] = 1'b1;
                    for (int i = 0; i < 32; i++)
                        mm[c][i] = 32'd0;
                end
            end
            rdp_m[c][0] = nrd[c][0];
            rdp_m[c][1] = nrd[c][1];
            coll_m[c]   = ncoll[c];
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        wen = '0; wa = '0; wd = '0; ra = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        for (int c = 0; c < NC; c++) begin
            n_cmp++;
            if (rdy_o[c] !== 1'b0) begin n_bad++; $display("FAIL reset_ready u%0d: got %b want 0", c, rdy_o[c]); end
            n_cmp++;
            if (coll_o[c] !== 1'b0) begin n_bad++; $display("FAIL reset_coll u%0d: got %b want 0", c, coll_o[c]); end
            n_cmp++;
            if (rd_o[c] !== 64'd0) begin n_bad++; $display("FAIL reset_rd u%0d: got %h want 0", c, rd_o[c]); end
        end
        rst_n = 1'b1;
        for (int e = 1; e <= 32; e++) begin
            tick();
            for (int c = 0; c < NC; c++) begin
                n_cmp++;
                if (rdy_o[c] !== (e >= cfg_depth[c])) begin
                    n_bad++; $display("FAIL sweep_ready u%0d edge %0d: got %b want %b", c, e, rdy_o[c], (e >= cfg_depth[c]));
                end
            end
        end
        for (int a = 0; a < 32; a++) begin
            ra = {5'(31 - a), 5'(a)};
            #1;
            for (int c = 0; c < NC; c++) begin
                n_cmp++;
                if (rd_o[c] !== 64'd0) begin n_bad++; $display("FAIL init_zero_comb u%0d ra %0d: got %h want 0", c, a, rd_o[c]); end
            end
            tick();
            for (int c = 0; c < NC; c++) begin
                n_cmp++;
                if (rd_o[c] !== 64'd0) begin n_bad++; $display("FAIL init_zero_reg u%0d ra %0d: got %h want 0", c, a, rd_o[c]); end
            end
        end
    endtask

    task automatic test_same_cycle_rw();
        wen = 2'b01; wa = {5'd0, 5'd5}; wd = {32'd0, 32'hDEADBEEF}; ra = {5'd0, 5'd5};
        #1;
        for (int c = 0; c < NC; c++) begin
            if (cfg_mode[c] == 0) begin
                n_cmp++;
                if (rd_o[c][31:0] !== 32'd0) begin n_bad++; $display("FAIL rw_mode0_old u%0d: got %h want 0", c, rd_o[c][31:0]); end
            end
        end
        tick();
        wen = 2'b00;
        for (int c = 0; c < NC; c++) begin
            n_cmp++;
            if (rd_o[c][31:0] !== ((cfg_mode[c] == 2) ? 32'd0 : 32'hDEADBEEF)) begin
                n_bad++; $display("FAIL rw_after_edge u%0d: got %h want %h", c, rd_o[c][31:0], (cfg_mode[c] == 2) ? 32'd0 : 32'hDEADBEEF);
            end
        end
        tick();
        n_cmp++;
        if (rd_o[2][31:0] !== 32'hDEADBEEF) begin n_bad++; $display("FAIL rw_mode2_late: got %h want deadbeef", rd_o[2][31:0]); end
    endtask

    task automatic test_zero_reg();
        wen = 2'b01; wa = {5'd0, 5'd0}; wd = {32'd0, 32'h1234}; ra = {5'd0, 5'd0};
        tick();
        wen = 2'b00;
        for (int c = 0; c < NC; c++) begin
            n_cmp++;
            if (coll_o[c] !== 1'b0) begin n_bad++; $display("FAIL r0_single_coll u%0d: got %b want 0", c, coll_o[c]); end
        end
        tick();
        for (int c = 0; c < NC; c++) begin
            n_cmp++;
            if (rd_o[c][31:0] !== ((cfg_zr[c] != 0) ? 32'd0 : 32'h1234)) begin
                n_bad++; $display("FAIL r0_read u%0d: got %h want %h", c, rd_o[c][31:0], (cfg_zr[c] != 0) ? 32'd0 : 32'h1234);
            end
        end
        wen = 2'b11; wa = {5'd0, 5'd0}; wd = {32'h99, 32'h77};
        tick();
        wen = 2'b00;
        for (int c = 0; c < NC; c++) begin
            n_cmp++;
            if (coll_o[c] !== (cfg_zr[c] == 0)) begin n_bad++; $display("FAIL r0_clash_coll u%0d: got %b want %b", c, coll_o[c], (cfg_zr[c] == 0)); end
        end
        tick();
        n_cmp++;
        if (rd_o[3][31:0] !== 32'h99) begin n_bad++; $display("FAIL r0_plain_winner: got %h want 99", rd_o[3][31:0]); end
        n_cmp++;
        if (rd_o[0][31:0] !== 32'd0) begin n_bad++; $display("FAIL r0_wired: got %h want 0", rd_o[0][31:0]); end
    endtask

    task automatic test_collision();
        wen = 2'b11; wa = {5'd7, 5'd7}; wd = {32'h22, 32'h11}; ra = {5'd7, 5'd7};
        tick();
        wen = 2'b00;
        for (int c = 0; c < NC; c++) begin
            n_cmp++;
            if (coll_o[c] !== 1'b1) begin n_bad++; $display("FAIL clash_pulse u%0d: got %b want 1", c, coll_o[c]); end
            n_cmp++;
            if (rd_o[c][31:0] !== ((cfg_mode[c] == 2) ? 32'd0 : 32'h22)) begin
                n_bad++; $display("FAIL clash_data u%0d: got %h want %h", c, rd_o[c][31:0], (cfg_mode[c] == 2) ? 32'd0 : 32'h22);
            end
        end
        tick();
        for (int c = 0; c < NC; c++) begin
            n_cmp++;
            if (coll_o[c] !== 1'b0) begin n_bad++; $display("FAIL clash_one_cycle u%0d: got %b want 0", c, coll_o[c]); end
            n_cmp++;
            if (rd_o[c][31:0] !== 32'h22) begin n_bad++; $display("FAIL clash_winner u%0d: got %h want 22", c, rd_o[c][31:0]); end
        end
        wen = 2'b11; wa = {5'd8, 5'd7}; wd = {32'hBB, 32'hAA}; ra = {5'd8, 5'd7};
        tick();
        wen = 2'b00;
        for (int c = 0; c < NC; c++) begin
            n_cmp++;
            if (coll_o[c] !== 1'b0) begin n_bad++; $display("FAIL distinct_coll u%0d: got %b want 0", c, coll_o[c]); end
        end
        tick();
        for (int c = 0; c < NC; c++) begin
            n_cmp++;
            if (rd_o[c] !== {32'hBB, 32'hAA}) begin n_bad++; $display("FAIL distinct_data u%0d: got %h want bb/aa", c, rd_o[c]); end
        end
        wen = 2'b01; wa = {5'd9, 5'd9}; wd = {32'h5, 32'h3}; ra = {5'd9, 5'd9};
        tick();
        wen = 2'b00;
        for (int c = 0; c < NC; c++) begin
            n_cmp++;
            if (coll_o[c] !== 1'b0) begin n_bad++; $display("FAIL disabled_coll u%0d: got %b want 0", c, coll_o[c]); end
        end
        tick();
        for (int c = 0; c < NC; c++) begin
            n_cmp++;
            if (rd_o[c][31:0] !== 32'h3) begin n_bad++; $display("FAIL disabled_data u%0d: got %h want 3", c, rd_o[c][31:0]); end
        end
        wen = 2'b11; wa = {5'd25, 5'd25}; wd = {32'h66, 32'h44}; ra = {5'd25, 5'd25};
        tick();
        wen = 2'b00;
        for (int c = 0; c < NC; c++) begin
            n_cmp++;
            if (coll_o[c] !== (cfg_depth[c] > 25)) begin n_bad++; $display("FAIL oor_coll u%0d: got %b want %b", c, coll_o[c], (cfg_depth[c] > 25)); end
        end
        tick();
        for (int c = 0; c < NC; c++) begin
            n_cmp++;
            if (rd_o[c][31:0] !== ((cfg_depth[c] > 25) ? 32'h66 : 32'd0)) begin
                n_bad++; $display("FAIL oor_data u%0d: got %h want %h", c, rd_o[c][31:0], (cfg_depth[c] > 25) ? 32'h66 : 32'd0);
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            wen = 2'($urandom_range(0, 3));
            wa[4:0] = 5'($urandom_range(0, 31));
            wa[9:5] = ($urandom_range(0, 3) == 0) ? wa[4:0] : 5'($urandom_range(0, 31));
            wd = {32'($urandom), 32'($urandom)};
            ra = {5'($urandom_range(0, 31)), 5'($urandom_range(0, 31))};
            if ($urandom_range(0, 3) == 0) ra[4:0] = wa[4:0];
            #1;
            for (int c = 0; c < NC; c++)
                if (cfg_mode[c] == 0)
                    for (int j = 0; j < 2; j++) begin
                        n_cmp++;
                        if (rd_o[c][j*32 +: 32] !== mread(c, ra_of(j))) begin
                            n_bad++; $display("FAIL rand_comb u%0d p%0d cyc %0d: got %h want %h", c, j, n, rd_o[c][j*32 +: 32], mread(c, ra_of(j)));
                        end
                    end
            tick();
            for (int c = 0; c < NC; c++) begin
                n_cmp++;
                if (coll_o[c] !== coll_m[c]) begin n_bad++; $display("FAIL rand_coll u%0d cyc %0d: got %b want %b", c, n, coll_o[c], coll_m[c]); end
                n_cmp++;
                if (rdy_o[c] !== rdy_m[c]) begin n_bad++; $display("FAIL rand_ready u%0d cyc %0d: got %b want %b", c, n, rdy_o[c], rdy_m[c]); end
                for (int j = 0; j < 2; j++) begin
                    n_cmp++;
                    if (rd_o[c][j*32 +: 32] !== exp_rd(c, j)) begin
                        n_bad++; $display("FAIL rand_rd u%0d p%0d cyc %0d: got %h want %h", c, j, n, rd_o[c][j*32 +: 32], exp_rd(c, j));
                    end
                end
            end
        end
        wen = 2'b00;
    endtask

    task automatic test_reset_midrun();
        wen = 2'b01; wa = {5'd0, 5'd5}; wd = {32'd0, 32'hDEADBEEF}; ra = {5'd0, 5'd5};
        tick();
        wen = 2'b00;
        tick();
        n_cmp++;
        if (rd_o[1][31:0] !== 32'hDEADBEEF) begin n_bad++; $display("FAIL midrun_pre u1: got %h want deadbeef", rd_o[1][31:0]); end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        for (int c = 0; c < NC; c++) begin
            n_cmp++;
            if (rdy_o[c] !== 1'b0) begin n_bad++; $display("FAIL midrun_ready u%0d: got %b want 0", c, rdy_o[c]); end
            n_cmp++;
            if (rd_o[c] !== 64'd0) begin n_bad++; $display("FAIL midrun_rd u%0d: got %h want 0", c, rd_o[c]); end
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ra = {5'd10, 5'd5};
        for (int e = 1; e <= 32; e++) begin
            if (e == 3) begin
                wen = 2'b01; wa = {5'd0, 5'd10}; wd = {32'd0, 32'h55};
            end
            #1;
            for (int c = 0; c < NC; c++) begin
                n_cmp++;
                if (rd_o[c] !== 64'd0) begin n_bad++; $display("FAIL init_rd u%0d edge %0d: got %h want 0", c, e, rd_o[c]); end
            end
            tick();
            wen = 2'b00;
            for (int c = 0; c < NC; c++) begin
                n_cmp++;
                if (rdy_o[c] !== (e >= cfg_depth[c])) begin
                    n_bad++; $display("FAIL resweep_ready u%0d edge %0d: got %b want %b", c, e, rdy_o[c], (e >= cfg_depth[c]));
                end
                n_cmp++;
                if (coll_o[c] !== 1'b0) begin n_bad++; $display("FAIL init_coll u%0d edge %0d: got %b want 0", c, e, coll_o[c]); end
            end
        end
        for (int a = 0; a < 32; a++) begin
            ra = {5'(31 - a), 5'(a)};
            tick();
            for (int c = 0; c < NC; c++) begin
                n_cmp++;
                if (rd_o[c] !== 64'd0) begin n_bad++; $display("FAIL resweep_zero u%0d ra %0d: got %h want 0", c, a, rd_o[c]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_same_cycle_rw();
        test_zero_reg();
        test_collision();
        test_random();
        test_reset_midrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
